dut_vector_sequencer: RTL and testbench



---
 rtl/dut_vector_sequencer.sv | 113 +++++++++++
 tb/tb_dut_vector_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dut_vector_sequencer.sv
// Shares one combinational DUT between two stimulus requesters: round-robin grant,
// registered DUT drive, one settle cycle, then a held and tagged response.
module dut_vector_sequencer #(
   parameter int DW   = 96,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [DW-1:0]   req0_data,
   input  logic [TAGW-1:0] req0_tag,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [DW-1:0]   req1_data,
   input  logic [TAGW-1:0] req1_tag,
   output logic [DW-1:0]   in_data,
   input  logic [DW-1:0]   out_data,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_data,
   output logic            rsp_src,
   output logic [TAGW-1:0] rsp_tag,
   output logic            busy,
   output logic [15:0]     issue_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t          state_reg;
   logic            prio_reg;
   logic [DW-1:0]   in_data_reg;
   logic [DW-1:0]   rsp_data_reg;
   logic            rsp_valid_reg;
   logic            rsp_src_reg;
   logic [TAGW-1:0] rsp_tag_reg;
   logic [15:0]     issue_cnt_reg;

   logic            grant;
   logic            accept;
   logic [DW-1:0]   grant_data;
   logic [TAGW-1:0] grant_tag;

   // A lone requester wins outright; prio only breaks ties.
   always_comb begin
      grant = prio_reg;
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end
      accept     = (state_reg == IDLE) && (req0_valid || req1_valid) && !rst;
      grant_data = grant ? req1_data : req0_data;
      grant_tag  = grant ? req1_tag : req0_tag;
   end

   assign req0_ready = accept && !grant;
   assign req1_ready = accept && grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         prio_reg      <= 1'b0;
         in_data_reg   <= '0;
         rsp_data_reg  <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_src_reg   <= 1'b0;
         rsp_tag_reg   <= '0;
         issue_cnt_reg <= 16'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  in_data_reg   <= grant_data;
                  rsp_src_reg   <= grant;
                  rsp_tag_reg   <= grant_tag;
                  prio_reg      <= ~grant;
                  issue_cnt_reg <= issue_cnt_reg + 16'd1;
                  state_reg     <= SETTLE;
               end
            end
            SETTLE: begin
               // in_data has been stable for a full cycle, so out_data is settled.
               rsp_data_reg  <= out_data;
               rsp_valid_reg <= 1'b1;
               state_reg     <= HOLD;
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign in_data   = in_data_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_src   = rsp_src_reg;
   assign rsp_tag   = rsp_tag_reg;
   assign busy      = (state_reg != IDLE);
   assign issue_cnt = issue_cnt_reg;

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Directed bench for dut_vector_sequencer; the DUT stub swaps the two 48-bit halves.
module tb_dut_vector_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [95:0] req0_data, req1_data, in_data, out_data, rsp_data;
   logic [3:0]  req0_tag, req1_tag, rsp_tag;
   logic        rsp_valid, rsp_ready, rsp_src, busy;
   logic [15:0] issue_cnt;

   int checks_total  = 0;
   int checks_passed = 0;

   always #5 clk = ~clk;

   assign out_data = {in_data[47:0], in_data[95:48]};

   dut_vector_sequencer #(.DW(96), .TAGW(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
      .in_data(in_data), .out_data(out_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_src(rsp_src), .rsp_tag(rsp_tag), .busy(busy), .issue_cnt(issue_cnt)
   );

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [95:0] D0 = 96'h111111111111_222222222222;
   localparam logic [95:0] X0 = 96'h222222222222_111111111111;
   localparam logic [95:0] D1 = 96'h333333333333_444444444444;
   localparam logic [95:0] X1 = 96'h444444444444_333333333333;
   localparam logic [95:0] D2 = 96'hDEADBEEF0000_00000000CAFE;
   localparam logic [95:0] X2 = 96'h00000000CAFE_DEADBEEF0000;
   localparam logic [95:0] D4 = 96'h0123456789AB_CDEF01234567;
   localparam logic [95:0] X4 = 96'hCDEF01234567_0123456789AB;

   initial begin
      int n, r, last, g;
      logic exp_src [6];

      rst = 1'b1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_data = '0; req1_data = '0; req0_tag = '0; req1_tag = '0;

      // Reset then idle; a valid during reset must not be acknowledged
      tick();
      req0_valid = 1; #1;
      chk("rst_ready0", 96'(req0_ready), 96'(0));
      tick();
      rst = 0; req0_valid = 0; #1;
      chk("rst_in_data", in_data, 96'(0));
      chk("rst_rsp_valid", 96'(rsp_valid), 96'(0));
      chk("rst_busy", 96'(busy), 96'(0));
      chk("rst_issue_cnt", 96'(issue_cnt), 96'(0));
      chk("rst_ready01", 96'({req0_ready, req1_ready}), 96'(0));

      // Single request
      req0_valid = 1; req0_data = 96'h1; req0_tag = 4'd3; #1;
      chk("single_ready0", 96'(req0_ready), 96'(1));
      chk("single_ready1", 96'(req1_ready), 96'(0));
      tick();
      req0_valid = 0;
      $display("accept src=0 tag=3 data=%h", 96'h1);
      chk("single_in_data", in_data, 96'h1);
      chk("single_rsp_valid_t1", 96'(rsp_valid), 96'(0));
      chk("single_busy", 96'(busy), 96'(1));
      chk("single_issue_cnt", 96'(issue_cnt), 96'(1));
      tick();
      chk("single_rsp_valid_t2", 96'(rsp_valid), 96'(1));
      chk("single_rsp_data", rsp_data, 96'h000000000001_000000000000);
      chk("single_rsp_src", 96'(rsp_src), 96'(0));
      chk("single_rsp_tag", 96'(rsp_tag), 96'(3));
      rsp_ready = 1;
      tick();
      chk("single_rsp_drop", 96'(rsp_valid), 96'(0));
      chk("single_idle", 96'(busy), 96'(0));

      // Contention: restart from reset so prio starts at requester 0
      rst = 1; tick(); rst = 0;
      req0_valid = 1; req0_data = D0; req0_tag = 4'hA;
      req1_valid = 1; req1_data = D1; req1_tag = 4'h5;
      n = 0; r = 0; last = 0;
      for (int cyc = 0; cyc < 40 && r < 6; cyc++) begin
         #1;
         chk("cont_onehot", 96'(req0_ready & req1_ready), 96'(0));
         if (rsp_valid) begin
            chk("cont_rsp_src", 96'(rsp_src), 96'(exp_src[r]));
            chk("cont_rsp_tag", 96'(rsp_tag), exp_src[r] ? 96'h5 : 96'hA);
            chk("cont_rsp_data", rsp_data, exp_src[r] ? X1 : X0);
            $display("response src=%0d tag=%0h", rsp_src, rsp_tag);
            r++;
         end
         if (req0_ready || req1_ready) begin
            g = int'(req1_ready);
            chk("cont_grant", 96'(g), 96'(n % 2));
            if (n > 0) chk("cont_gap", 96'(cyc - last), 96'(3));
            last = cyc;
            exp_src[n] = req1_ready;
            $display("accept src=%0d n=%0d cycle=%0d", g, n, cyc);
            n++;
         end
         tick();
         if (n == 6) begin req0_valid = 0; req1_valid = 0; end
      end
      chk("cont_accepts", 96'(n), 96'(6));
      chk("cont_responses", 96'(r), 96'(6));
      chk("cont_issue_cnt", 96'(issue_cnt), 96'(6));

      // Backpressure: requester 1 keeps asking while the response is held
      rsp_ready = 0;
      req0_valid = 1; req0_data = D2; req0_tag = 4'd5;
      req1_valid = 1; req1_data = D1; req1_tag = 4'd9; #1;
      chk("bp_ready0", 96'(req0_ready), 96'(1));
      tick();
      req0_valid = 0;
      $display("accept src=0 tag=5 data=%h", D2);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_valid", 96'(rsp_valid), 96'(1));
         chk("bp_rsp_data", rsp_data, X2);
         chk("bp_rsp_tag", 96'(rsp_tag), 96'(5));
         chk("bp_rsp_src", 96'(rsp_src), 96'(0));
         chk("bp_readys", 96'({req0_ready, req1_ready}), 96'(0));
         chk("bp_busy", 96'(busy), 96'(1));
         tick();
      end
      rsp_ready = 1;
      tick();
      chk("bp_exit_busy", 96'(busy), 96'(0));
      chk("bp_exit_rsp_valid", 96'(rsp_valid), 96'(0));
      chk("bp_ready1", 96'(req1_ready), 96'(1));
      tick();
      req1_valid = 0; rsp_ready = 0;
      $display("accept src=1 tag=9 data=%h", D1);

      // Reset in SETTLE drops the in-flight vector
      rst = 1; tick(); rst = 0;
      chk("rs_rsp_valid", 96'(rsp_valid), 96'(0));
      chk("rs_in_data", in_data, 96'(0));
      chk("rs_issue_cnt", 96'(issue_cnt), 96'(0));
      chk("rs_busy", 96'(busy), 96'(0));
      chk("rs_rsp_src_tag", 96'({rsp_src, rsp_tag}), 96'(0));
      chk("rs_rsp_data", rsp_data, 96'(0));
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rs_no_rsp", 96'(rsp_valid), 96'(0));
      end

      // Counter wrap; lone requester 1 granted although prio points at 0
      force dut.issue_cnt_reg = 16'hFFFF;
      #1;
      chk("wrap_preload", 96'(issue_cnt), 96'hFFFF);
      release dut.issue_cnt_reg;
      req1_valid = 1; req1_data = D4; req1_tag = 4'd7; #1;
      chk("wrap_ready1", 96'(req1_ready), 96'(1));
      chk("wrap_ready0", 96'(req0_ready), 96'(0));
      tick();
      req1_valid = 0;
      $display("accept src=1 tag=7 data=%h", D4);
      chk("wrap_issue_cnt", 96'(issue_cnt), 96'(0));
      chk("wrap_in_data", in_data, D4);
      tick();
      chk("wrap_rsp", {rsp_data[91:0], rsp_valid, rsp_src, rsp_tag[1:0]},
          {X4[91:0], 1'b1, 1'b1, 2'b11});
      rsp_ready = 1;
      tick();
      req0_valid = 1; req1_valid = 1; #1;
      chk("wrap_prio_flip", 96'({req0_ready, req1_ready}), 96'b10);
      req0_valid = 0; req1_valid = 0;

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
